// File: rtl/cpu_ctrl_pkg.sv
// Shared constants for the multi-cycle control path: opcodes, ALU ops, state encoding.
package cpu_ctrl_pkg;

  // Instruction opcodes (IR[15:12])
  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_BEQ  = 4'b0101;
  localparam logic [3:0] OP_LOAD = 4'b0110;
  localparam logic [3:0] OP_HALT = 4'b1111;

  // ALU operation codes; R-type opcodes map 1:1 onto these
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_XOR = 4'b0100;

  typedef enum logic [2:0] {
    StIdle      = 3'd0,
    StFetch     = 3'd1,
    StDecode    = 3'd2,
    StExecute   = 3'd3,
    StMem       = 3'd4,
    StWriteback = 3'd5,
    StHalt      = 3'd6,
    StError     = 3'd7
  } state_e;

  function automatic logic is_rtype(input logic [3:0] op);
    return op <= OP_XOR;
  endfunction

  // 0111..1110 are reserved and execute as NOP
  function automatic logic is_unused(input logic [3:0] op);
    return (op >= 4'b0111) && (op <= 4'b1110);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles spent waiting on a memory ready; flags timeout in the last allowed cycle.
module mem_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic waiting,
  input  logic ready,
  output logic timeout
);

  localparam int unsigned CntW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(MEM_TIMEOUT - 1);

  logic [CntW-1:0] cnt_q;

  // cnt_q holds (cycle index within the wait state) - 1
  assign timeout = waiting && !ready && (cnt_q == LastCnt);

  // Wait counter: cleared on state entry, advances on each cycle without ready
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (waiting && !ready && (cnt_q != LastCnt)) begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle control FSM for the 16-bit RISC core: fetch/decode/execute/mem/writeback.
module multicycle_controller
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned COUNT_W     = 16,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  input  logic [3:0]         opcode,
  input  logic               alu_zero,
  input  logic               imem_ready,
  input  logic               dmem_ready,
  output logic               imem_req,
  output logic               ir_write,
  output logic               pc_write,
  output logic               pc_src,
  output logic [3:0]         alu_op,
  output logic               alu_src_imm,
  output logic               dmem_req,
  output logic               reg_write,
  output logic               mem_to_reg,
  output logic               halted,
  output logic               error,
  output logic               illegal,
  output logic [2:0]         state,
  output logic [COUNT_W-1:0] instr_count
);

  state_e             state_q, state_d;
  logic [3:0]         op_q;
  logic               illegal_q, illegal_d;
  logic [COUNT_W-1:0] count_q;
  logic               retire;
  logic               waiting, ready_sel, timer_clear, timeout;

  assign state       = state_q;
  assign illegal     = illegal_q;
  assign instr_count = count_q;

  assign waiting     = (state_q == StFetch) || (state_q == StMem);
  assign ready_sel   = (state_q == StFetch) ? imem_ready : dmem_ready;
  assign timer_clear = (state_d != state_q) && ((state_d == StFetch) || (state_d == StMem));

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (timer_clear),
    .waiting(waiting),
    .ready  (ready_sel),
    .timeout(timeout)
  );

  // State, latched opcode, sticky illegal flag and retirement counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      op_q      <= '0;
      illegal_q <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      if (state_q == StDecode) op_q <= opcode;
      if (retire) count_q <= count_q + COUNT_W'(1);
    end
  end

  // Next-state and control decode
  always_comb begin
    state_d     = state_q;
    illegal_d   = illegal_q;
    retire      = 1'b0;
    imem_req    = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    pc_src      = 1'b0;
    alu_op      = ALU_ADD;
    alu_src_imm = 1'b0;
    dmem_req    = 1'b0;
    reg_write   = 1'b0;
    mem_to_reg  = 1'b0;
    halted      = 1'b0;
    error       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (run) state_d = StFetch;
      end
      StFetch: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = StDecode;
        end else if (timeout) begin
          state_d = StError;
        end
      end
      StDecode: begin
        if (opcode == OP_HALT) begin
          state_d = StHalt;
        end else if (is_unused(opcode)) begin
          illegal_d = 1'b1;
          state_d   = run ? StFetch : StIdle;
        end else begin
          state_d = StExecute;
        end
      end
      StExecute: begin
        if (is_rtype(op_q)) begin
          alu_op  = op_q;
          state_d = StWriteback;
        end else if (op_q == OP_BEQ) begin
          alu_op = ALU_SUB;
          if (alu_zero) begin
            pc_write = 1'b1;
            pc_src   = 1'b1;
          end
          retire  = 1'b1;
          state_d = run ? StFetch : StIdle;
        end else if (op_q == OP_LOAD) begin
          alu_op      = ALU_ADD;
          alu_src_imm = 1'b1;
          state_d     = StMem;
        end else begin
          // Unreachable: DECODE never forwards other opcodes here
          state_d = run ? StFetch : StIdle;
        end
      end
      StMem: begin
        dmem_req = 1'b1;
        if (dmem_ready) begin
          state_d = StWriteback;
        end else if (timeout) begin
          state_d = StError;
        end
      end
      StWriteback: begin
        reg_write  = 1'b1;
        mem_to_reg = (op_q == OP_LOAD);
        retire     = 1'b1;
        state_d    = run ? StFetch : StIdle;
      end
      StHalt: begin
        halted = 1'b1;
      end
      StError: begin
        error = 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed-vector bench: stimulus pushes hand-computed expectations, monitor pops and compares.
module tb_multicycle_controller;

  logic        clk = 1'b0;
  logic        reset, run, alu_zero, imem_ready, dmem_ready;
  logic [3:0]  opcode;
  logic        imem_req, ir_write, pc_write, pc_src, alu_src_imm, dmem_req;
  logic        reg_write, mem_to_reg, halted, error, illegal;
  logic [3:0]  alu_op;
  logic [2:0]  state;
  logic [15:0] instr_count;

  always #5 clk = ~clk;

  multicycle_controller #(
    .COUNT_W    (16),
    .MEM_TIMEOUT(15)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .opcode     (opcode),
    .alu_zero   (alu_zero),
    .imem_ready (imem_ready),
    .dmem_ready (dmem_ready),
    .imem_req   (imem_req),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .pc_src     (pc_src),
    .alu_op     (alu_op),
    .alu_src_imm(alu_src_imm),
    .dmem_req   (dmem_req),
    .reg_write  (reg_write),
    .mem_to_reg (mem_to_reg),
    .halted     (halted),
    .error      (error),
    .illegal    (illegal),
    .state      (state),
    .instr_count(instr_count)
  );

  typedef struct {
    int          id;
    logic [2:0]  st;
    logic [14:0] ctl;
    logic [15:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   step_id = 0;
  bit   stim_done = 1'b0;

  // Control vector order:
  // imem_req ir_write pc_write pc_src alu_op[3:0] alu_src_imm dmem_req reg_write mem_to_reg
  // halted error illegal
  function automatic logic [14:0] mk(input logic im, input logic irw, input logic pcw,
                                     input logic pcs, input logic [3:0] aop, input logic imm,
                                     input logic dr, input logic rw, input logic m2r,
                                     input logic h, input logic e, input logic il);
    return {im, irw, pcw, pcs, aop, imm, dr, rw, m2r, h, e, il};
  endfunction

  localparam logic [2:0] SI = 3'd0, SF = 3'd1, SD = 3'd2, SE = 3'd3;
  localparam logic [2:0] SM = 3'd4, SW = 3'd5, SH = 3'd6, SX = 3'd7;

  logic [14:0] c_zero, c_fwait, c_fgo, c_beq_t, c_beq_f, c_ld, c_mem, c_wb_r, c_wb_ld;
  logic [14:0] c_halt_il, c_err, c_or3;

  // One clock cycle of stimulus plus the outputs expected during that cycle
  task automatic cyc(input logic rst, input logic rn, input logic [3:0] op, input logic z,
                     input logic ir, input logic dr, input logic [2:0] est,
                     input logic [14:0] ectl, input logic [15:0] ecnt);
    exp_t e;
    @(posedge clk);
    #1;
    reset      = rst;
    run        = rn;
    opcode     = op;
    alu_zero   = z;
    imem_ready = ir;
    dmem_ready = dr;
    e.id  = step_id;
    e.st  = est;
    e.ctl = ectl;
    e.cnt = ecnt;
    exp_q.push_back(e);
    step_id++;
  endtask

  // Monitor: compares every presented cycle against the oldest pending expectation
  initial begin
    exp_t        e;
    logic [14:0] act;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        act = {imem_req, ir_write, pc_write, pc_src, alu_op, alu_src_imm, dmem_req,
               reg_write, mem_to_reg, halted, error, illegal};
        n_cmp++;
        if (state !== e.st || act !== e.ctl || instr_count !== e.cnt) begin
          n_bad++;
          $display("FAIL step%0d: state=%0d ctl=%b cnt=%0d, required state=%0d ctl=%b cnt=%0d",
                   e.id, state, act, instr_count, e.st, e.ctl, e.cnt);
        end
      end
    end
  end

  initial begin
    c_zero    = mk(0,0,0,0,4'b0000,0,0,0,0,0,0,0);
    c_fwait   = mk(1,0,0,0,4'b0000,0,0,0,0,0,0,0);
    c_fgo     = mk(1,1,1,0,4'b0000,0,0,0,0,0,0,0);
    c_beq_t   = mk(0,0,1,1,4'b0001,0,0,0,0,0,0,0);
    c_beq_f   = mk(0,0,0,0,4'b0001,0,0,0,0,0,0,0);
    c_ld      = mk(0,0,0,0,4'b0000,1,0,0,0,0,0,0);
    c_mem     = mk(0,0,0,0,4'b0000,0,1,0,0,0,0,0);
    c_wb_r    = mk(0,0,0,0,4'b0000,0,0,1,0,0,0,0);
    c_wb_ld   = mk(0,0,0,0,4'b0000,0,0,1,1,0,0,0);
    c_halt_il = mk(0,0,0,0,4'b0000,0,0,0,0,1,0,1);
    c_err     = mk(0,0,0,0,4'b0000,0,0,0,0,0,1,0);
    c_or3     = mk(0,0,0,0,4'b0011,0,0,0,0,0,0,0);

    reset = 1'b1; run = 1'b0; opcode = 4'h0; alu_zero = 1'b0;
    imem_ready = 1'b0; dmem_ready = 1'b0;

    // Reset state, then R-type ADD: 4-cycle loop
    cyc(1, 0, 4'h0, 0, 1, 1, SI, c_zero, 0);
    cyc(0, 1, 4'h0, 0, 1, 1, SI, c_zero, 0);
    cyc(0, 1, 4'h0, 0, 1, 1, SF, c_fgo, 0);
    cyc(0, 1, 4'h0, 0, 1, 1, SD, c_zero, 0);
    cyc(0, 1, 4'h0, 0, 1, 1, SE, c_zero, 0);
    cyc(0, 1, 4'h5, 0, 1, 1, SW, c_wb_r, 0);
    // BEQ taken, then not taken: 3-cycle loops
    cyc(0, 1, 4'h5, 0, 1, 1, SF, c_fgo, 1);
    cyc(0, 1, 4'h5, 1, 1, 1, SD, c_zero, 1);
    cyc(0, 1, 4'h5, 1, 1, 1, SE, c_beq_t, 1);
    cyc(0, 1, 4'h5, 0, 1, 1, SF, c_fgo, 2);
    cyc(0, 1, 4'h5, 0, 1, 1, SD, c_zero, 2);
    cyc(0, 1, 4'h6, 0, 1, 1, SE, c_beq_f, 2);
    // LOAD with dmem_ready delayed 3 cycles: 8-cycle loop
    cyc(0, 1, 4'h6, 0, 1, 0, SF, c_fgo, 3);
    cyc(0, 1, 4'h6, 0, 1, 0, SD, c_zero, 3);
    cyc(0, 1, 4'h6, 0, 1, 0, SE, c_ld, 3);
    cyc(0, 1, 4'h6, 0, 1, 0, SM, c_mem, 3);
    cyc(0, 1, 4'h6, 0, 1, 0, SM, c_mem, 3);
    cyc(0, 1, 4'h6, 0, 1, 0, SM, c_mem, 3);
    cyc(0, 1, 4'h6, 0, 1, 1, SM, c_mem, 3);
    cyc(0, 1, 4'hA, 0, 1, 1, SW, c_wb_ld, 3);
    // Unused opcode 1010: 2-cycle loop, sticky illegal, no retirement
    cyc(0, 1, 4'hA, 0, 1, 1, SF, c_fgo, 4);
    cyc(0, 1, 4'hA, 0, 1, 1, SD, c_zero, 4);
    cyc(0, 1, 4'hF, 0, 1, 1, SF, c_fgo | 15'd1, 4);
    // HALT is terminal; run toggles ignored
    cyc(0, 0, 4'hF, 0, 1, 1, SD, 15'd1, 4);
    cyc(0, 1, 4'h0, 0, 1, 1, SH, c_halt_il, 4);
    cyc(0, 0, 4'h0, 0, 1, 1, SH, c_halt_il, 4);
    cyc(0, 1, 4'h0, 0, 1, 1, SH, c_halt_il, 4);
    // Reset clears everything, then imem_ready held low -> ERROR after 15 FETCH cycles
    cyc(1, 1, 4'h0, 0, 0, 0, SI, c_zero, 0);
    cyc(0, 1, 4'h0, 0, 0, 0, SI, c_zero, 0);
    for (int i = 0; i < 15; i++) cyc(0, 1, 4'h0, 0, 0, 0, SF, c_fwait, 0);
    cyc(0, 1, 4'h0, 0, 1, 1, SX, c_err, 0);
    cyc(0, 0, 4'h0, 0, 1, 1, SX, c_err, 0);
    // Ready in the 15th FETCH cycle wins; then OR (0011)
    cyc(1, 1, 4'h3, 0, 0, 0, SI, c_zero, 0);
    cyc(0, 1, 4'h3, 0, 0, 0, SI, c_zero, 0);
    for (int i = 0; i < 14; i++) cyc(0, 1, 4'h3, 0, 0, 0, SF, c_fwait, 0);
    cyc(0, 1, 4'h3, 0, 1, 1, SF, c_fgo, 0);
    cyc(0, 1, 4'h3, 0, 1, 1, SD, c_zero, 0);
    cyc(0, 1, 4'h3, 0, 1, 1, SE, c_or3, 0);
    cyc(0, 1, 4'h6, 0, 1, 1, SW, c_wb_r, 0);
    // LOAD interrupted by reset during MEM
    cyc(0, 1, 4'h6, 0, 1, 0, SF, c_fgo, 1);
    cyc(0, 1, 4'h6, 0, 1, 0, SD, c_zero, 1);
    cyc(0, 1, 4'h6, 0, 1, 0, SE, c_ld, 1);
    cyc(0, 1, 4'h6, 0, 1, 0, SM, c_mem, 1);
    cyc(1, 1, 4'h6, 0, 1, 1, SI, c_zero, 0);
    cyc(0, 0, 4'h6, 0, 1, 1, SI, c_zero, 0);
    cyc(0, 0, 4'h6, 0, 1, 1, SI, c_zero, 0);

    // Drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    stim_done = 1'b1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
